// File: rtl/width_arb_pkg.sv
// Shared types and helpers for the round-robin width-adapter arbiter.
package width_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // $clog2 with a floor of 1 so that single-value ranges still get a real bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 32'd2) ? 32'd1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req[] bit after 'last', wrapping modulo N.
module rr_pick
  import width_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned ID_W = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int unsigned cand;

  always_comb begin
    idx  = last;
    any  = 1'b0;
    cand = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last) + k) % N;
      if (!any && req[ID_W'(cand)]) begin
        any = 1'b1;
        idx = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/width_adapter_arbiter.sv
// Round-robin arbiter feeding a narrow-to-wide width adapter; grants are held for one full word.
// Optional per-requester completed-word counters enabled by `WIDTH_ARB_STATS_EN.
module width_adapter_arbiter
  import width_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned SIZE_IN  = 8,
  parameter int unsigned SIZE_OUT = 32,
  localparam int unsigned ID_W = clog2_min1(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][SIZE_IN-1:0]  req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIZE_IN-1:0]               out_data,
  output logic [ID_W-1:0]                  out_id,
`ifdef WIDTH_ARB_STATS_EN
  input  logic                             stats_clear,
  output logic [NUM_REQ-1:0][15:0]         word_cnt,
`endif
  output logic                             out_last
);

  localparam int unsigned BEATS = SIZE_OUT / SIZE_IN;
  localparam int unsigned CNT_W = clog2_min1(BEATS);

  if ((SIZE_OUT % SIZE_IN) != 0 || SIZE_OUT < SIZE_IN) begin : g_size_check
    $error("width_adapter_arbiter: SIZE_OUT must be a non-zero multiple of SIZE_IN");
  end

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   last_win_q, last_win_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [ID_W-1:0]   grant;
  logic              word_end;
  logic              xfer;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req_valid),
    .last (last_win_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_win_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Grant mux, handshake outputs and next-state; all outputs forced low while in reset.
  always_comb begin
    state_d    = state_q;
    last_win_d = last_win_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    grant      = last_win_q;

    if (state_q == IDLE && pick_any) grant = pick_idx;

    word_end  = (BEATS == 1) ? 1'b1 : (beat_cnt_q == CNT_W'(BEATS - 1));
    out_valid = !reset && req_valid[grant];
    out_data  = reset ? '0 : req_data[grant];
    out_id    = reset ? '0 : grant;
    out_last  = !reset && word_end;
    if (!reset && out_ready) req_ready[grant] = 1'b1;
    xfer = out_valid && out_ready;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          last_win_d = grant;
          if (BEATS > 1) begin
            beat_cnt_d = CNT_W'(1);
            state_d    = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          if (word_end) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WIDTH_ARB_STATS_EN
  // Saturating count of completed words per requester; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      word_cnt <= '0;
    end else if (xfer && out_last && word_cnt[grant] != 16'hFFFF) begin
      word_cnt[grant] <= word_cnt[grant] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_width_adapter_arbiter.sv
// Directed self-checking bench for width_adapter_arbiter (BEATS=4 instance and BEATS=1 instance).
module tb_width_adapter_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, reset1;
  logic [3:0]       req_valid, req_valid1;
  logic [3:0][7:0]  req_data;
  logic [3:0]       req_ready, req_ready1;
  logic             out_valid, out_valid1;
  logic             out_ready, out_ready1;
  logic [7:0]       out_data, out_data1;
  logic [1:0]       out_id, out_id1;
  logic             out_last, out_last1;
`ifdef WIDTH_ARB_STATS_EN
  logic             stats_clear, stats_clear1;
  logic [3:0][15:0] word_cnt, word_cnt1;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  width_adapter_arbiter #(.NUM_REQ(4), .SIZE_IN(8), .SIZE_OUT(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id),
`ifdef WIDTH_ARB_STATS_EN
    .stats_clear(stats_clear), .word_cnt(word_cnt),
`endif
    .out_last(out_last)
  );

  width_adapter_arbiter #(.NUM_REQ(4), .SIZE_IN(8), .SIZE_OUT(8)) dut1 (
    .clk(clk), .reset(reset1), .req_valid(req_valid1), .req_data(req_data),
    .req_ready(req_ready1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_id(out_id1),
`ifdef WIDTH_ARB_STATS_EN
    .stats_clear(stats_clear1), .word_cnt(word_cnt1),
`endif
    .out_last(out_last1)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, req_ready, out_last, out_id, out_data} !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b rdy=%b last=%b id=%0d data=%h, need all 0",
               out_valid, req_ready, out_last, out_id, out_data);
    end
    tick(); tick();
    reset = 1'b0; req_valid = 4'h0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] eid;
    logic       elast;
    apply_reset();
    req_valid = 4'hF; out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      #1;
      eid = (b < 4) ? 2'd0 : 2'd1;
      elast = ((b % 4) == 3);
      tests_run++;
      if ({out_valid, out_id, out_last, req_ready} !== {1'b1, eid, elast, 4'(4'b1 << eid)}) begin
        tests_failed++;
        $display("FAIL reset_first_grant beat %0d: got v=%b id=%0d last=%b rdy=%b, need id=%0d last=%b",
                 b, out_valid, out_id, out_last, req_ready, eid, elast);
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    int words [4];
    logic [1:0] eid;
    logic       elast;
    for (int i = 0; i < 4; i++) words[i] = 0;
    apply_reset();
    req_valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      #1;
      eid = 2'((c / 4) % 4);
      elast = ((c % 4) == 3);
      tests_run++;
      if ({out_valid, out_id, out_last} !== {1'b1, eid, elast}) begin
        tests_failed++;
        $display("FAIL fairness cycle %0d: got v=%b id=%0d last=%b, need id=%0d last=%b",
                 c, out_valid, out_id, out_last, eid, elast);
      end
      if (out_valid && out_ready && out_last) words[out_id]++;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (words[i] !== 4) begin
        tests_failed++;
        $display("FAIL fairness_words req %0d: got %0d words, need 4", i, words[i]);
      end
    end
`ifdef WIDTH_ARB_STATS_EN
    tests_run++;
    if (word_cnt !== {16'd4, 16'd4, 16'd4, 16'd4}) begin
      tests_failed++;
      $display("FAIL fairness_word_cnt: got %h, need all 0004", word_cnt);
    end
`endif
  endtask

  task automatic test_lock_hold();
    apply_reset();
    req_valid = 4'b0010; out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      #1;
      tests_run++;
      if ({out_valid, out_id, out_last, req_ready} !== {1'b1, 2'd1, 1'b0, 4'b0010}) begin
        tests_failed++;
        $display("FAIL lock_first_beats %0d: got v=%b id=%0d last=%b rdy=%b, need v=1 id=1 last=0 rdy=0010",
                 b, out_valid, out_id, out_last, req_ready);
      end
      tick();
    end
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if ({out_valid, out_id, req_ready[2]} !== {1'b0, 2'd1, 1'b0}) begin
        tests_failed++;
        $display("FAIL lock_hold cycle %0d: got v=%b id=%0d rdy2=%b, need v=0 id=1 rdy2=0",
                 c, out_valid, out_id, req_ready[2]);
      end
      tick();
    end
    req_valid = 4'b0110;
    for (int b = 0; b < 3; b++) begin
      #1;
      tests_run++;
      if (b < 2) begin
        if ({out_valid, out_id, out_last, req_ready} !== {1'b1, 2'd1, (b == 1), 4'b0010}) begin
          tests_failed++;
          $display("FAIL lock_finish beat %0d: got v=%b id=%0d last=%b rdy=%b, need id=1 last=%b",
                   b + 3, out_valid, out_id, out_last, req_ready, (b == 1));
        end
      end else if ({out_valid, out_id, out_last, req_ready} !== {1'b1, 2'd2, 1'b0, 4'b0100}) begin
        tests_failed++;
        $display("FAIL lock_next_grant: got v=%b id=%0d last=%b rdy=%b, need id=2 last=0 rdy=0100",
                 out_valid, out_id, out_last, req_ready);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_valid = 4'hF; out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if ({out_valid, out_id, out_last, req_ready, out_data} !== {1'b1, 2'd0, 1'b0, 4'b0000, 8'hA0}) begin
        tests_failed++;
        $display("FAIL backpressure cycle %0d: got v=%b id=%0d last=%b rdy=%b data=%h, need v=1 id=0 last=0 rdy=0 data=a0",
                 c, out_valid, out_id, out_last, req_ready, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      #1;
      tests_run++;
      if (b < 2) begin
        if ({out_id, out_last, req_ready, out_data} !== {2'd0, (b == 1), 4'b0001, 8'hA0}) begin
          tests_failed++;
          $display("FAIL backpressure_resume beat %0d: got id=%0d last=%b rdy=%b data=%h, need id=0 last=%b",
                   b + 3, out_id, out_last, req_ready, out_data, (b == 1));
        end
      end else if ({out_id, out_last, out_data} !== {2'd1, 1'b0, 8'hA1}) begin
        tests_failed++;
        $display("FAIL backpressure_next: got id=%0d last=%b data=%h, need id=1 last=0 data=a1",
                 out_id, out_last, out_data);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_word();
    apply_reset();
    req_valid = 4'b1000; out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      #1;
      tests_run++;
      if ({out_valid, out_id, out_data} !== {1'b1, 2'd3, 8'hA3}) begin
        tests_failed++;
        $display("FAIL midreset_req3 beat %0d: got v=%b id=%0d data=%h, need v=1 id=3 data=a3",
                 b, out_valid, out_id, out_data);
      end
      tick();
    end
    reset = 1'b1; req_valid = 4'hF;
    #1;
    tests_run++;
    if ({out_valid, req_ready, out_last, out_id, out_data} !== 16'h0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got v=%b rdy=%b last=%b id=%0d data=%h, need all 0",
               out_valid, req_ready, out_last, out_id, out_data);
    end
    tick();
    reset = 1'b0;
    for (int b = 0; b < 5; b++) begin
      #1;
      tests_run++;
      if ({out_valid, out_id, out_last} !== {1'b1, (b < 4) ? 2'd0 : 2'd1, (b == 3)}) begin
        tests_failed++;
        $display("FAIL midreset_regrant beat %0d: got v=%b id=%0d last=%b, need id=%0d last=%b",
                 b, out_valid, out_id, out_last, (b < 4) ? 0 : 1, (b == 3));
      end
      tick();
    end
  endtask

  task automatic test_single_beat();
    logic [1:0] eid;
    reset1 = 1'b1; req_valid1 = 4'b0101; out_ready1 = 1'b1;
    #1;
    tests_run++;
    if ({out_valid1, req_ready1, out_last1, out_id1, out_data1} !== 16'h0) begin
      tests_failed++;
      $display("FAIL beats1_reset_outputs: got v=%b rdy=%b last=%b id=%0d data=%h, need all 0",
               out_valid1, req_ready1, out_last1, out_id1, out_data1);
    end
    tick(); tick();
    reset1 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      eid = (c % 2 == 0) ? 2'd0 : 2'd2;
      tests_run++;
      if ({out_valid1, out_id1, out_last1, req_ready1} !== {1'b1, eid, 1'b1, 4'(4'b1 << eid)}) begin
        tests_failed++;
        $display("FAIL beats1_alternate cycle %0d: got v=%b id=%0d last=%b rdy=%b, need id=%0d last=1",
                 c, out_valid1, out_id1, out_last1, req_ready1, eid);
      end
      tick();
    end
`ifdef WIDTH_ARB_STATS_EN
    out_ready1 = 1'b0;
    tests_run++;
    if (word_cnt1 !== {16'd0, 16'd8, 16'd0, 16'd8}) begin
      tests_failed++;
      $display("FAIL beats1_word_cnt: got %h, need 0000_0008_0000_0008", word_cnt1);
    end
    out_ready1 = 1'b1; stats_clear1 = 1'b1;
    tick();
    stats_clear1 = 1'b0; out_ready1 = 1'b0;
    #1;
    tests_run++;
    if (word_cnt1 !== 64'h0) begin
      tests_failed++;
      $display("FAIL beats1_stats_clear: got %h, need all 0", word_cnt1);
    end
`endif
    req_valid1 = 4'h0;
  endtask

  initial begin
    reset = 1'b1; reset1 = 1'b1;
    req_valid = 4'h0; req_valid1 = 4'h0;
    out_ready = 1'b0; out_ready1 = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i] = 8'(8'hA0 + i);
`ifdef WIDTH_ARB_STATS_EN
    stats_clear = 1'b0; stats_clear1 = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_fairness();
    test_lock_hold();
    test_backpressure();
    test_reset_mid_word();
    test_single_beat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
